// File: rtl/deferred_ctrl_pkg.sv
// Shared definitions for the deferred commit-step controller.
//   - SIMV_* result codes exchanged with the host and driven on simv_result
//   - STEP_W_DEFAULT: default width of the per-cycle commit step count
//   - result_state_e: states of the simv_result holding machine
//   - simv_code_clean(): folds unknown host return codes to SIMV_NONE
// Build option: DEFERRED_CTRL_INTERNAL_STEP_EN (see deferred_control.sv).
package deferred_ctrl_pkg;

  localparam int STEP_W_DEFAULT = 8;

  typedef logic [7:0] simv_code_t;

  localparam simv_code_t SIMV_NONE = 8'h0;
  localparam simv_code_t SIMV_DONE = 8'h1;
  localparam simv_code_t SIMV_FAIL = 8'h2;

  // IDLE shows SIMV_NONE, DONE lasts a single cycle, FAIL holds until reset.
  typedef enum logic [1:0] {
    RES_IDLE,
    RES_DONE,
    RES_FAIL
  } result_state_e;

  // Anything the host returns other than DONE or FAIL means "nothing to report".
  function automatic simv_code_t simv_code_clean(input simv_code_t code);
    return ((code == SIMV_DONE) || (code == SIMV_FAIL)) ? code : SIMV_NONE;
  endfunction

endpackage

// File: rtl/deferred_control_if.sv
// Bus between the deferred controller and its host environment.
//   step         : instructions committed this cycle (external-step build only)
//   simv_result  : registered result code seen by the host
//   nstep_call   : host hook strobe, simv_nstep_deferred(nstep_count) this edge
//   nstep_count  : argument of that call
//   nstep_ret    : host return code for that call, valid while nstep_call is high
//   fetch_call   : host hook strobe, simv_result_fetch() this edge (internal-step build)
//   fetch_ret    : host return code for that call
// A host hook "call" is one cycle with the strobe high; the host answers
// combinationally on *_ret and the controller registers the answer on that edge.
// Modports: slave = controller, master = host / stimulus side.
// Build option: DEFERRED_CTRL_INTERNAL_STEP_EN removes step and the nstep hook
// and adds the fetch hook instead.
interface deferred_control_if #(
  parameter int STEP_W = deferred_ctrl_pkg::STEP_W_DEFAULT
);
  import deferred_ctrl_pkg::*;

  simv_code_t simv_result;

`ifndef DEFERRED_CTRL_INTERNAL_STEP_EN
  logic [STEP_W-1:0] step;
  logic              nstep_call;
  logic [31:0]       nstep_count;
  simv_code_t        nstep_ret;

  modport slave (
    input  step,
    input  nstep_ret,
    output nstep_call,
    output nstep_count,
    output simv_result
  );

  modport master (
    output step,
    output nstep_ret,
    input  nstep_call,
    input  nstep_count,
    input  simv_result
  );
`else
  logic       fetch_call;
  simv_code_t fetch_ret;

  modport slave (
    input  fetch_ret,
    output fetch_call,
    output simv_result
  );

  modport master (
    output fetch_ret,
    input  fetch_call,
    input  simv_result
  );
`endif

endinterface

// File: rtl/deferred_step_accum.sv
// Step accumulator and flush decision for the deferred controller.
// Ports:
//   clock, reset : single clock, synchronous active-high reset
//   step         : commit count for this cycle (external-step build only)
//   count        : flush argument, saturating acc + step (external-step build only)
//   flush        : high during a cycle whose rising edge is a flush edge
// Default build: flush when the running total reaches BATCH_LIMIT, or at the
// last cycle of a FLUSH_INTERVAL window if anything is pending. The first cycle
// after reset is a dead cycle that ignores step.
// With DEFERRED_CTRL_INTERNAL_STEP_EN defined, acc and the batch logic vanish
// and flush simply marks the last cycle of every FLUSH_INTERVAL window.
module deferred_step_accum
  import deferred_ctrl_pkg::*;
#(
  parameter int STEP_W         = STEP_W_DEFAULT,
  parameter int BATCH_LIMIT    = 256,
  parameter int FLUSH_INTERVAL = 4096
) (
  input  logic              clock,
  input  logic              reset,
`ifndef DEFERRED_CTRL_INTERNAL_STEP_EN
  input  logic [STEP_W-1:0] step,
  output logic [31:0]       count,
`endif
  output logic              flush
);

  localparam logic [31:0] CYC_LAST = 32'(FLUSH_INTERVAL - 1);

  logic [31:0] cyc_reg;
  logic [31:0] cyc_next;
  logic        cyc_at_last;

  assign cyc_at_last = (cyc_reg == CYC_LAST);

`ifndef DEFERRED_CTRL_INTERNAL_STEP_EN
  localparam logic [31:0] BATCH_MAX = 32'(BATCH_LIMIT);

  logic [31:0] acc_reg;
  logic [31:0] acc_next;
  logic        first_reg;
  logic [32:0] sum;
  logic [31:0] nxt;

  // One extra bit catches the carry so the total pins at 2^32-1.
  always_comb begin
    sum = {1'b0, acc_reg} + 33'(step);
    nxt = sum[32] ? '1 : sum[31:0];
  end

  always_comb begin
    flush    = 1'b0;
    acc_next = acc_reg;
    cyc_next = cyc_reg;
    // Reset and the dead first cycle leave acc/cyc alone and never flush.
    if (!reset && !first_reg) begin
      flush = (nxt >= BATCH_MAX) || (cyc_at_last && (nxt != '0));
      if (flush) begin
        acc_next = '0;
        cyc_next = '0;
      end else begin
        acc_next = nxt;
        // Reaching the window end without a flush means nothing is pending.
        cyc_next = cyc_at_last ? '0 : cyc_reg + 32'd1;
      end
    end
  end

  assign count = nxt;

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_reg   <= '0;
      cyc_reg   <= '0;
      first_reg <= 1'b1;
    end else begin
      acc_reg   <= acc_next;
      cyc_reg   <= cyc_next;
      first_reg <= 1'b0;
    end
  end
`else
  always_comb begin
    flush    = !reset && cyc_at_last;
    cyc_next = cyc_at_last ? '0 : cyc_reg + 32'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cyc_reg <= '0;
    end else begin
      cyc_reg <= cyc_next;
    end
  end
`endif

endmodule

// File: rtl/deferred_control.sv
// Deferred commit-step controller: batches commit steps and reports them to
// the host through a hook, then turns the host's answer into simv_result.
// Ports:
//   clock, reset : single clock, synchronous active-high reset
//   bus          : deferred_control_if.slave (step, simv_result, host hooks)
// Result behaviour: DONE is shown for one cycle, FAIL sticks until reset,
// any other host answer reads as NONE. A fresh answer replaces a showing DONE.
// Build option: DEFERRED_CTRL_INTERNAL_STEP_EN -- no step input; the host is
// polled through simv_result_fetch() once per FLUSH_INTERVAL cycles instead
// of being handed batched step counts.
module deferred_control
  import deferred_ctrl_pkg::*;
#(
  parameter int STEP_W         = STEP_W_DEFAULT,
  parameter int BATCH_LIMIT    = 256,
  parameter int FLUSH_INTERVAL = 4096
) (
  input logic               clock,
  input logic               reset,
  deferred_control_if.slave bus
);

  logic          flush;
  simv_code_t    host_code;
  result_state_e state_reg;
  result_state_e state_next;

`ifndef DEFERRED_CTRL_INTERNAL_STEP_EN
  deferred_step_accum #(
    .STEP_W         (STEP_W),
    .BATCH_LIMIT    (BATCH_LIMIT),
    .FLUSH_INTERVAL (FLUSH_INTERVAL)
  ) u_accum (
    .clock (clock),
    .reset (reset),
    .step  (bus.step),
    .count (bus.nstep_count),
    .flush (flush)
  );

  // simv_nstep_deferred(count): one strobe cycle per flush edge.
  assign bus.nstep_call = flush;
  assign host_code      = simv_code_clean(bus.nstep_ret);
`else
  deferred_step_accum #(
    .STEP_W         (STEP_W),
    .BATCH_LIMIT    (BATCH_LIMIT),
    .FLUSH_INTERVAL (FLUSH_INTERVAL)
  ) u_accum (
    .clock (clock),
    .reset (reset),
    .flush (flush)
  );

  // simv_result_fetch(): one strobe cycle per interval end.
  assign bus.fetch_call = flush;
  assign host_code      = simv_code_clean(bus.fetch_ret);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= RES_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = RES_IDLE;
    unique case (state_reg)
      RES_FAIL: state_next = RES_FAIL;
      default: begin
        if (flush) begin
          unique case (host_code)
            SIMV_DONE: state_next = RES_DONE;
            SIMV_FAIL: state_next = RES_FAIL;
            default:   state_next = RES_IDLE;
          endcase
        end
      end
    endcase
  end

  always_comb begin
    bus.simv_result = SIMV_NONE;
    unique case (state_reg)
      RES_DONE: bus.simv_result = SIMV_DONE;
      RES_FAIL: bus.simv_result = SIMV_FAIL;
      default:  bus.simv_result = SIMV_NONE;
    endcase
  end

endmodule

// File: tb/tb_deferred_control.sv
// Bench for deferred_control with BATCH_LIMIT=4, FLUSH_INTERVAL=8.
// The bench plays the host: it answers each hook strobe from a queue of
// return codes and logs every call it sees.
module tb_deferred_control;
  import deferred_ctrl_pkg::*;

  localparam int STEP_W = 8;
  localparam int BL     = 4;
  localparam int FI     = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  deferred_control_if #(.STEP_W(STEP_W)) bus ();

  deferred_control #(
    .STEP_W         (STEP_W),
    .BATCH_LIMIT    (BL),
    .FLUSH_INTERVAL (FI)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int     checks   = 0;
  int     failures = 0;
  int     ret_q[$];
  longint call_log[$];

  // Reference state: pending steps, cycles into the window, dead-cycle flag,
  // and the result code that must be visible.
  longint m_acc   = 0;
  int     m_cyc   = 0;
  bit     m_first = 1'b1;
  int     m_res   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint last_call();
    return (call_log.size() > 0) ? call_log[call_log.size()-1] : -1;
  endfunction

  // Compare process: at every falling edge check simv_result, predict what the
  // coming rising edge must do, answer any host call, and advance the model.
  initial begin : monitor
    bit     exp_call;
    longint exp_cnt;
    int     code;
`ifndef DEFERRED_CTRL_INTERNAL_STEP_EN
    bus.nstep_ret = SIMV_NONE;
`else
    bus.fetch_ret = SIMV_NONE;
`endif
    forever begin
      @(negedge clock);
      check("simv_result", 64'(bus.simv_result), 64'(m_res));
      exp_call = 1'b0;
      exp_cnt  = 0;
`ifndef DEFERRED_CTRL_INTERNAL_STEP_EN
      if (!reset && !m_first) begin
        exp_cnt = m_acc + longint'(bus.step);
        if (exp_cnt > 64'hFFFF_FFFF) exp_cnt = 64'hFFFF_FFFF;
        exp_call = (exp_cnt >= BL) || ((m_cyc == FI - 1) && (exp_cnt != 0));
      end
      check("nstep_call", 64'(bus.nstep_call), 64'(exp_call));
      if (exp_call) check("nstep_count", 64'(bus.nstep_count), exp_cnt);
      if (bus.nstep_call) call_log.push_back(longint'(bus.nstep_count));
      code = 0;
      if (bus.nstep_call || exp_call) code = (ret_q.size() > 0) ? ret_q.pop_front() : 0;
      bus.nstep_ret = 8'(code);
      if (reset) begin
        m_acc = 0; m_cyc = 0; m_first = 1'b1; m_res = 0;
      end else if (m_first) begin
        m_first = 1'b0;
        if (m_res != 2) m_res = 0;
      end else begin
        if (m_res != 2) m_res = (exp_call && (code == 1 || code == 2)) ? code : 0;
        if (exp_call) begin
          m_acc = 0; m_cyc = 0;
        end else begin
          m_acc = exp_cnt; m_cyc = (m_cyc + 1) % FI;
        end
      end
`else
      exp_call = !reset && (m_cyc == FI - 1);
      check("fetch_call", 64'(bus.fetch_call), 64'(exp_call));
      if (bus.fetch_call) call_log.push_back(0);
      code = 0;
      if (bus.fetch_call || exp_call) code = (ret_q.size() > 0) ? ret_q.pop_front() : 0;
      bus.fetch_ret = 8'(code);
      if (reset) begin
        m_cyc = 0; m_res = 0;
      end else begin
        if (m_res != 2) m_res = (exp_call && (code == 1 || code == 2)) ? code : 0;
        m_cyc = (m_cyc + 1) % FI;
      end
`endif
    end
  end

  // Apply step/reset for n rising edges; returns 1 time unit after the last one.
  task automatic drive(input int stp, input bit rst, input int n = 1);
    for (int i = 0; i < n; i++) begin
`ifndef DEFERRED_CTRL_INTERNAL_STEP_EN
      bus.step = STEP_W'(stp);
`endif
      reset = rst;
      @(posedge clock);
      #1;
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin : stimulus
    int n_before;
`ifndef DEFERRED_CTRL_INTERNAL_STEP_EN
    bus.step = '0;
    drive(0, 1'b1, 2);
    check("reset_result", 64'(bus.simv_result), 0);

    // Dead first cycle: a large step must be ignored.
    drive(9, 1'b0, 1);
    check("first_cycle_no_call", call_log.size(), 0);

    // Batch limit: 1+1+1+1 flushes on the 4th edge with count 4.
    ret_q.push_back(0);
    drive(1, 1'b0, 3);
    check("batch_pending", call_log.size(), 0);
    drive(1, 1'b0, 1);
    check("batch_calls", call_log.size(), 1);
    check("batch_count", 64'(last_call()), 4);

    // Interval flush: single step, flush when the window closes, then silence.
    ret_q.push_back(0);
    drive(1, 1'b0, 1);
    drive(0, 1'b0, 6);
    check("interval_pending", call_log.size(), 1);
    drive(0, 1'b0, 1);
    check("interval_calls", call_log.size(), 2);
    check("interval_count", 64'(last_call()), 1);
    drive(0, 1'b0, 24);
    check("idle_no_call", call_log.size(), 2);

    // DONE lasts one cycle.
    ret_q.push_back(1);
    drive(5, 1'b0, 1);
    check("done_count", 64'(last_call()), 5);
    check("done_shown", 64'(bus.simv_result), 1);
    drive(0, 1'b0, 1);
    check("done_cleared", 64'(bus.simv_result), 0);

    // Unknown return code reads as NONE.
    ret_q.push_back(7);
    drive(4, 1'b0, 1);
    check("bad_code", 64'(bus.simv_result), 0);

    // New DONE on top of a showing DONE.
    ret_q.push_back(1);
    drive(4, 1'b0, 1);
    ret_q.push_back(1);
    drive(4, 1'b0, 1);
    check("done_again", 64'(bus.simv_result), 1);
    drive(0, 1'b0, 1);
    check("done_again_cleared", 64'(bus.simv_result), 0);

    // FAIL sticks through a later DONE until reset.
    ret_q.push_back(2);
    drive(4, 1'b0, 1);
    check("fail_shown", 64'(bus.simv_result), 2);
    ret_q.push_back(1);
    drive(4, 1'b0, 1);
    check("fail_over_done", 64'(bus.simv_result), 2);
    drive(0, 1'b0, 10);
    check("fail_sticky", 64'(bus.simv_result), 2);
    n_before = call_log.size();
    drive(0, 1'b1, 1);
    check("fail_reset", 64'(bus.simv_result), 0);

    // Reset mid-accumulation discards 3 pending steps without a call.
    drive(0, 1'b0, 1);
    drive(1, 1'b0, 3);
    drive(0, 1'b1, 1);
    check("discard_no_call", call_log.size(), n_before);
    drive(0, 1'b0, 1);
    ret_q.push_back(0);
    drive(2, 1'b0, 1);
    check("discard_pending", call_log.size(), n_before);
    drive(2, 1'b0, 1);
    check("discard_calls", call_log.size(), n_before + 1);
    check("discard_count", 64'(last_call()), 4);
    drive(0, 1'b0, 4);
`else
    ret_q.push_back(0);
    ret_q.push_back(0);
    ret_q.push_back(1);
    drive(0, 1'b1, 2);
    check("reset_result", 64'(bus.simv_result), 0);
    drive(0, 1'b0, 23);
    check("fetch_two", call_log.size(), 2);
    check("fetch_none_yet", 64'(bus.simv_result), 0);
    drive(0, 1'b0, 1);
    check("fetch_three", call_log.size(), 3);
    check("fetch_done", 64'(bus.simv_result), 1);
    drive(0, 1'b0, 1);
    check("fetch_done_cleared", 64'(bus.simv_result), 0);
    drive(0, 1'b0, 4);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/deferred_control.md
DEFERRED_CONTROL -- requirements
Module: deferred_control

Interface
REQ-001 Parameter STEP_W, default 8 (CONFIG_DIFFTEST_STEPWIDTH); width of the per-cycle commit step count.
REQ-002 Parameter BATCH_LIMIT, default 256; accumulated step count that forces a flush.
REQ-003 Parameter FLUSH_INTERVAL, default 4096; maximum number of cycles between flushes.
REQ-004 Port clock, input, 1 bit; single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1 bit; synchronous, active-high.
REQ-006 Port step, input, STEP_W bits; number of instructions committed this cycle (0 = none).
REQ-007 Port simv_result, output, 8 bits; 0 = none, 1 = DONE, 2 = FAIL.
REQ-008 Host hooks: imported function simv_nstep_deferred(int count) returns byte; imported function simv_result_fetch() returns byte (internal-step mode only).

Function
REQ-009 The block SHALL keep a 32-bit step accumulator acc, a 32-bit cycle counter cyc, and a first-cycle flag.
REQ-010 The first non-reset cycle after reset deassertion SHALL ignore step and only clear the first-cycle flag.
REQ-011 On every later cycle, the flush candidate SHALL be nxt = acc + step, saturating at 2^32-1.
REQ-012 A flush SHALL occur when nxt >= BATCH_LIMIT, or when cyc == FLUSH_INTERVAL-1 and nxt != 0.
REQ-013 On a flush edge, the block SHALL call simv_nstep_deferred(nxt) exactly once, clear acc to 0 and clear cyc to 0.
REQ-014 On a non-flush edge, acc SHALL take nxt and cyc SHALL increment, wrapping to 0 after FLUSH_INTERVAL-1 when nxt == 0.
REQ-015 The flush return code SHALL be registered into simv_result on the flush edge, giving a latency of one edge from the last sampled step.
REQ-016 Return codes other than 1 or 2 SHALL be treated as 0.
REQ-017 DONE (1) SHALL be held for exactly one cycle; simv_result SHALL then return to 0 unless a new code arrives.
REQ-018 FAIL (2) SHALL be sticky until reset; later codes SHALL be ignored while FAIL is held.
REQ-019 Non-flush edges SHALL write 0 to simv_result, except while FAIL is held.
REQ-020 If a flush and a held DONE coincide, the new code SHALL win.

Reset
REQ-021 While reset is high: acc = 0, cyc = 0, first-cycle flag set, simv_result = 0, and no host call is made.
REQ-022 Reset asserted mid-accumulation SHALL discard pending steps without calling the host.

Configuration
REQ-023 Macro DEFERRED_CTRL_INTERNAL_STEP_EN; when undefined, the step port exists and REQ-009..REQ-020 apply.
REQ-024 When DEFERRED_CTRL_INTERNAL_STEP_EN is defined:
- the step port SHALL be removed, and acc and the BATCH_LIMIT logic SHALL be omitted;
- the block SHALL call simv_result_fetch() once whenever cyc == FLUSH_INTERVAL-1, with cyc wrapping to 0;
- the returned code SHALL be handled per REQ-015..REQ-020.

Structure
REQ-025 A shared package deferred_ctrl_pkg SHALL hold constants SIMV_NONE = 8'h0, SIMV_DONE = 8'h1 and SIMV_FAIL = 8'h2, plus the default STEP_W.
REQ-026 One sub-module, deferred_step_accum, SHALL implement acc/cyc and the flush decision, outputting flush and count.
REQ-027 The top level SHALL hold the host calls and the simv_result register.

Verification (BATCH_LIMIT=4, FLUSH_INTERVAL=8)
REQ-028 step=1 for 4 consecutive cycles after the first cycle -> exactly one call with count 4 on the 4th edge; acc = 0 afterwards.
REQ-029 step=1 on one cycle, then 0 -> call with count 1 when cyc reaches 7; no call occurs in later idle intervals.
REQ-030 step=5 in a single cycle, host returns 1 -> simv_result = 1 for exactly one cycle, then 0.
REQ-031 Host returns 2 on a flush, then 1 on the next flush -> simv_result stays 2 until reset, then reads 0.
REQ-032 Accumulate acc = 3, then pulse reset for 1 cycle -> no host call; the next flush count excludes the discarded 3.
REQ-033 DEFERRED_CTRL_INTERNAL_STEP_EN defined, host returns 0,0,1 -> fetch called every 8 cycles; simv_result = 1 for one cycle after the third fetch.
